// File: rtl/nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : nibble_serial_subtractor                                    |
// | Brief  : N*4-bit subtract, one nibble per cycle, start/busy/done     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+

module nibble_serial_subtractor #(
  parameter int NIBBLES = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [4*NIBBLES-1:0] A,
  input  logic [4*NIBBLES-1:0] B,
  input  logic                 bin,
  output logic [4*NIBBLES-1:0] D,
  output logic                 Bout,
  output logic                 ovf,
  output logic                 busy,
  output logic                 done
);

  localparam int c_width = 4 * NIBBLES;
  localparam int c_idx_w = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [c_idx_w-1:0] c_last = c_idx_w'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [c_width-1:0]   a_sh_q, a_sh_d;
  logic [c_width-1:0]   b_sh_q, b_sh_d;
  logic [c_width-1:0]   d_q, d_d;
  logic [c_idx_w-1:0]   idx_q, idx_d;
  logic                 borrow_q, borrow_d;
  logic                 bout_q, bout_d;
  logic                 ovf_q, ovf_d;
  logic                 a_msb_q, a_msb_d;
  logic                 b_msb_q, b_msb_d;

  logic [3:0]           w_sub_d;
  logic                 w_sub_bout;

  parallel_subtractor u_sub (
    .A    (a_sh_q[3:0]),
    .B    (b_sh_q[3:0]),
    .c    (borrow_q),
    .D    (w_sub_d),
    .Bout (w_sub_bout)
  );

  always_comb begin
    state_d  = state_q;
    a_sh_d   = a_sh_q;
    b_sh_d   = b_sh_q;
    d_d      = d_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    bout_d   = bout_q;
    ovf_d    = ovf_q;
    a_msb_d  = a_msb_q;
    b_msb_d  = b_msb_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Sign bits are kept aside because the shift registers lose them.
          a_sh_d   = A;
          b_sh_d   = B;
          a_msb_d  = A[c_width-1];
          b_msb_d  = B[c_width-1];
          borrow_d = bin;
          idx_d    = '0;
          d_d      = '0;
          bout_d   = 1'b0;
          ovf_d    = 1'b0;
          state_d  = S_RUN;
        end else begin
          state_d  = S_IDLE;
        end
      end

      S_RUN: begin
        for (int i = 0; i < NIBBLES; i++) begin
          if (idx_q == c_idx_w'(i)) begin
            d_d[4*i +: 4] = w_sub_d;
          end
        end
        borrow_d = w_sub_bout;
        a_sh_d   = a_sh_q >> 4;
        b_sh_d   = b_sh_q >> 4;
        if (idx_q == c_last) begin
          bout_d  = w_sub_bout;
          ovf_d   = (a_msb_q ^ b_msb_q) & (w_sub_d[3] ^ a_msb_q);
          state_d = S_DONE;
        end else begin
          idx_d   = idx_q + 1'b1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_sh_q   <= '0;
      b_sh_q   <= '0;
      d_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      bout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      a_msb_q  <= 1'b0;
      b_msb_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_sh_q   <= a_sh_d;
      b_sh_q   <= b_sh_d;
      d_q      <= d_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      bout_q   <= bout_d;
      ovf_q    <= ovf_d;
      a_msb_q  <= a_msb_d;
      b_msb_q  <= b_msb_d;
    end
  end

  assign D    = d_q;
  assign Bout = bout_q;
  assign ovf  = ovf_q;
  assign busy = (state_q == S_RUN);
  assign done = (state_q == S_DONE);

endmodule

// 4-bit combinational subtract: D = A-B-c mod 16, Bout set when A < B+c.
module parallel_subtractor (
  input  logic [3:0] A,
  input  logic [3:0] B,
  input  logic       c,
  output logic [3:0] D,
  output logic       Bout
);

  logic [4:0] w_diff;

  // The fifth bit is the sign of A-B-c, i.e. the borrow.
  assign w_diff = {1'b0, A} - {1'b0, B} - {4'b0000, c};
  assign D      = w_diff[3:0];
  assign Bout   = w_diff[4];

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_subtractor.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_nibble_serial_subtractor                                 |
// | Brief  : scoreboard bench for nibble_serial_subtractor (NIBBLES=4)   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+

module tb_nibble_serial_subtractor;

  localparam int N = 4;
  localparam int W = 4 * N;

  typedef struct {
    logic [W-1:0] d;
    logic         bout;
    logic         ovf;
    int           acc;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] A, B;
  logic         bin;
  logic [W-1:0] D;
  logic         Bout, ovf, busy, done;

  exp_t         sb[$];
  int           cyc = 0;
  int           n_vec = 0;
  int           n_cmp = 0;
  int           n_err = 0;
  int           busy_run = 0;
  exp_t         last_exp;

  nibble_serial_subtractor #(.NIBBLES(N)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .A     (A),
    .B     (B),
    .bin   (bin),
    .D     (D),
    .Bout  (Bout),
    .ovf   (ovf),
    .busy  (busy),
    .done  (done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: whole-word integer arithmetic, no nibble slicing.
  function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t   e;
    longint ua = longint'(a);
    longint ub = longint'(b);
    longint diff = ua - ub - longint'(bi);
    e.d    = W'(diff);
    e.bout = (ua < ub + longint'(bi));
    e.ovf  = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
    e.acc  = 0;
    return e;
  endfunction

  task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bi);
    exp_t e;
    A = a; B = b; bin = bi; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    e = model(a, b, bi);
    e.acc = cyc;
    sb.push_back(e);
    last_exp = e;
    n_vec++;
    A = W'($urandom); B = W'($urandom); bin = 1'($urandom);
  endtask

  // Leaves the bench just after the edge that enters DONE.
  task automatic wait_slot();
    repeat (N) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT reports done.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) begin
        busy_run++;
      end else if (busy_run != 0) begin
        check("busy_len", 64'(busy_run), 64'(N));
        busy_run = 0;
      end
      if (done) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_err++;
          $display("FAIL unexpected_done: done=1 with no pending op, D=%0h (t=%0t)", D, $time);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("D", 64'(D), 64'(e.d));
          check("Bout", 64'(Bout), 64'(e.bout));
          check("ovf", 64'(ovf), 64'(e.ovf));
          check("latency", 64'(cyc - e.acc), 64'(N));
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; start = 1'b0; A = '0; B = '0; bin = 1'b0;
    idle(2);
    check("rst_D", 64'(D), 64'd0);
    check("rst_Bout", 64'(Bout), 64'd0);
    check("rst_ovf", 64'(ovf), 64'd0);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    rst = 1'b0;
    idle(1);

    issue(16'h1234, 16'h0235, 1'b0); wait_slot(); idle(1);
    issue(16'h0000, 16'h0001, 1'b0); wait_slot(); idle(1);
    issue(16'hFFFF, 16'hFFFF, 1'b1); wait_slot();
    issue(16'h0009, 16'h0005, 1'b0); wait_slot(); idle(1);
    issue(16'h8000, 16'h0001, 1'b0); wait_slot(); idle(1);

    // Start pulse mid-operation must be ignored.
    issue(16'h5A5A, 16'h1111, 1'b0);
    A = 16'h0F0F; B = 16'hF0F0; bin = 1'b1; start = 1'b1;
    idle(1);
    start = 1'b0;
    idle(N - 2);
    idle(2);

    // Async reset two cycles into RUN aborts the operation.
    issue(16'h7777, 16'h1234, 1'b1);
    repeat (2) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_done", 64'(done), 64'd0);
    check("arst_D", 64'(D), 64'd0);
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(N + 2);
    issue(16'h4321, 16'h1234, 1'b0); wait_slot(); idle(1);

    for (int i = 0; i < 40; i++) begin
      issue(W'($urandom), W'($urandom), 1'($urandom));
      wait_slot();
      idle($urandom_range(0, 2));
    end

    for (int t = 0; t < 50 && sb.size() != 0; t++) @(posedge clk);
    if (sb.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL drain: %0d results never appeared", sb.size());
    end

    idle(N + 3);
    check("hold_D", 64'(D), 64'(last_exp.d));
    check("hold_Bout", 64'(Bout), 64'(last_exp.bout));
    check("hold_ovf", 64'(ovf), 64'(last_exp.ovf));
    check("idle_busy", 64'(busy), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
